// File: rtl/tone_player.sv
// tone_player: single-channel square-wave note player with millisecond-accurate duration.
// Ports: clk, rst_n (synchronous, active-low); note_valid/note_ready handshake carrying
// note_code (0..7 = C5..C6, 8..15 = rest), octave (pitch x 2^octave) and dur_ms;
// stop aborts a playing note; output_note drives the buzzer; busy is high while a note
// plays; done pulses for one cycle when a note completes normally.
module tone_player #(
   parameter int CLK_HZ = 12000000,
   parameter int CNT_W  = 16,
   parameter int DUR_W  = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             note_valid,
   output logic             note_ready,
   input  logic [3:0]       note_code,
   input  logic [1:0]       octave,
   input  logic [DUR_W-1:0] dur_ms,
   input  logic             stop,
   output logic             output_note,
   output logic             busy,
   output logic             done
);
   localparam int T    = CLK_HZ / 1000;
   localparam int PS_W = $clog2(T);
   // Base half-periods CLK_HZ/(2*f) for C5 D5 E5 F5 G5 A5 B5 C6
   localparam logic [CNT_W-1:0] H0 [8] = '{
      CNT_W'(CLK_HZ / 1046), CNT_W'(CLK_HZ / 1174), CNT_W'(CLK_HZ / 1318), CNT_W'(CLK_HZ / 1396),
      CNT_W'(CLK_HZ / 1568), CNT_W'(CLK_HZ / 1760), CNT_W'(CLK_HZ / 1976), CNT_W'(CLK_HZ / 2094)};
   typedef enum logic [1:0] {IDLE, PLAY, DONE} state_t;
   state_t           state_q, state_d;
   logic [3:0]       code_q;
   logic [1:0]       oct_q;
   logic [DUR_W-1:0] rem_q, rem_d;
   logic [CNT_W-1:0] cnt_q, cnt_d, half;
   logic [PS_W-1:0]  ps_q, ps_d;
   logic             tone_q, tone_d, busy_q, done_q, ready_q;
   logic             accept, cnt_wrap, ps_wrap, expire;
   assign accept   = note_valid && ready_q;
   assign half     = H0[code_q[2:0]] >> oct_q;
   assign cnt_wrap = cnt_q == half - 1'b1;
   assign ps_wrap  = ps_q == PS_W'(T - 1);
   assign expire   = ps_wrap && rem_q == DUR_W'(1);
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      ps_d    = ps_q;
      rem_d   = rem_q;
      tone_d  = 1'b0;
      case (state_q)
         IDLE: if (accept) begin
            cnt_d   = '0;
            ps_d    = '0;
            rem_d   = dur_ms;
            state_d = dur_ms == '0 ? DONE : PLAY;
         end
         PLAY: if (stop) state_d = IDLE;
         else begin
            cnt_d   = cnt_wrap ? '0 : cnt_q + 1'b1;
            ps_d    = ps_wrap ? '0 : ps_q + 1'b1;
            rem_d   = ps_wrap ? rem_q - 1'b1 : rem_q;
            // rest codes (bit 3 set) keep the counters running but never toggle
            tone_d  = (cnt_wrap ? tone_q ^ ~code_q[3] : tone_q) && !expire;
            state_d = expire ? DONE : PLAY;
         end
         default: state_d = IDLE;
      endcase
   end
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         ps_q    <= '0;
         rem_q   <= '0;
         code_q  <= '0;
         oct_q   <= '0;
         tone_q  <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         ready_q <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         ps_q    <= ps_d;
         rem_q   <= rem_d;
         tone_q  <= tone_d;
         busy_q  <= state_q == PLAY && !stop;
         done_q  <= state_q == DONE;
         ready_q <= state_q == IDLE && !accept;
         if (accept) begin
            code_q <= note_code;
            oct_q  <= octave;
         end
      end
   end
   assign note_ready  = ready_q;
   assign output_note = tone_q;
   assign busy        = busy_q;
   assign done        = done_q;
endmodule

// File: tb/tb_tone_player.sv
// tb_tone_player: self-checking bench for tone_player at a scaled clock (T = 240 cycles/ms).
// A cycle-level reference model built from note timing arithmetic checks every output on
// every cycle; a vector table and hand sequences check pitch, duration and corner cases.
module tb_tone_player;
   localparam int CLK_HZ = 240000;
   localparam int T      = CLK_HZ / 1000;
   localparam int FREQ [8] = '{523, 587, 659, 698, 784, 880, 988, 1047};
   logic        clk = 1'b0, rst_n = 1'b0, note_valid = 1'b0, stop = 1'b0;
   logic [3:0]  note_code = '0;
   logic [1:0]  octave = '0;
   logic [15:0] dur_ms = '0;
   logic        note_ready, output_note, busy, done;
   int          checks = 0, errors = 0;
   tone_player #(.CLK_HZ(CLK_HZ), .CNT_W(16), .DUR_W(16)) dut (
      .clk(clk), .rst_n(rst_n), .note_valid(note_valid), .note_ready(note_ready),
      .note_code(note_code), .octave(octave), .dur_ms(dur_ms), .stop(stop),
      .output_note(output_note), .busy(busy), .done(done));
   always #5 clk = ~clk;
   function automatic int half_period(input int code, input int oct);
      return (CLK_HZ / (2 * FREQ[code % 8])) >> oct;
   endfunction
   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
      end
   endtask
   // Reference model: a note is described by cycles elapsed since its accept edge (m_n),
   // its play length N = dur*T and its half-period H.
   bit m_en = 0, m_fly = 0, m_tone = 0;
   int m_n = 0, m_N = 0, m_H = 1;
   bit e_ready = 0, e_busy = 0, e_done = 0, e_out = 0;
   initial forever begin : model
      bit acc, idle_prev;
      @(posedge clk);
      if (!rst_n) begin
         m_en = 1; m_fly = 0;
         e_ready = 0; e_busy = 0; e_done = 0; e_out = 0;
      end else begin
         acc = note_valid && e_ready;
         idle_prev = !m_fly;
         e_done = 0;
         if (m_fly && stop && m_n < m_N) m_fly = 0;
         else if (m_fly) begin
            m_n++;
            e_done = m_n == m_N + 1;
            if (m_n > m_N) m_fly = 0;
         end
         if (acc) begin
            m_fly = 1; m_n = 0; m_N = int'(dur_ms) * T;
            m_H = half_period(int'(note_code), int'(octave));
            m_tone = note_code < 8;
         end
         e_ready = idle_prev && !acc;
         e_busy  = m_fly && m_n >= 1 && m_n <= m_N;
         e_out   = m_fly && m_tone && m_n >= m_H && m_n < m_N && ((m_n / m_H) % 2 == 1);
      end
   end
   initial forever begin
      @(negedge clk);
      if (m_en) begin
         check("model_ready", note_ready, e_ready);
         check("model_busy", busy, e_busy);
         check("model_done", done, e_done);
         check("model_out", output_note, e_out);
      end
   end
   task automatic start_note(input int code, input int oct, input int dur);
      int k = 0;
      while (!note_ready && k < 5000) begin @(negedge clk); k++; end
      check("ready_wait", note_ready, 1);
      note_valid = 1; note_code = 4'(code); octave = 2'(oct); dur_ms = 16'(dur);
      @(negedge clk);
      note_valid = 0;
   endtask
   task automatic play(input int code, input int oct, input int dur,
                       output int first, output int changes, output int donec);
      logic prev = 1'b0;
      first = 0; changes = 0; donec = -1;
      start_note(code, oct, dur);
      for (int n = 0; n < 3000; n++) begin
         if (n > 0) @(negedge clk);
         if (output_note !== prev) begin
            changes++;
            if (output_note && first == 0) first = n;
         end
         prev = output_note;
         if (done) begin donec = n; break; end
      end
   endtask
   typedef struct {int code; int oct; int dur; int first; int changes; int donec;} vec_t;
   vec_t tbl [7];
   initial begin
      int f, c, d, dn;
      tbl[0] = '{5, 0, 1, 136, 2, 241};
      tbl[1] = '{0, 2, 5, 57, 22, 1201};
      tbl[2] = '{15, 0, 2, 0, 0, 481};
      tbl[3] = '{7, 0, 0, 0, 0, 1};
      tbl[4] = '{6, 3, 1, 15, 16, 241};
      tbl[5] = '{3, 1, 2, 85, 6, 481};
      tbl[6] = '{2, 0, 3, 182, 4, 721};
      @(negedge clk);
      check("rst_ready", note_ready, 0);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_out", output_note, 0);
      rst_n = 1;
      @(negedge clk);
      check("ready_after_rst", note_ready, 1);
      foreach (tbl[i]) begin
         play(tbl[i].code, tbl[i].oct, tbl[i].dur, f, c, d);
         check($sformatf("t%0d_first_rise", i), f, tbl[i].first);
         check($sformatf("t%0d_changes", i), c, tbl[i].changes);
         check($sformatf("t%0d_done_cycle", i), d, tbl[i].donec);
         check($sformatf("t%0d_out_at_done", i), output_note, 0);
      end
      // dur 0 with note_valid held: second command taken on the first ready cycle
      start_note(7, 0, 0);
      note_valid = 1; note_code = 5; dur_ms = 1;
      @(negedge clk); check("d0_done_c1", done, 1);
      @(negedge clk); check("d0_ready_c2", note_ready, 1);
      @(negedge clk); check("d0_ready_c3", note_ready, 0);
      note_valid = 0;
      @(negedge clk); check("d0_busy_second", busy, 1);
      // new command held mid-note must not disturb the playing pitch
      start_note(5, 0, 1);
      for (int n = 1; n <= 360; n++) begin
         @(negedge clk);
         if (n == 50) begin note_valid = 1; note_code = 0; octave = 1; dur_ms = 1; end
         if (n == 114) check("hold_out_c114", output_note, 0);
         if (n == 136) check("hold_out_c136", output_note, 1);
         if (n == 241) check("hold_done", done, 1);
         if (n == 242) check("hold_ready", note_ready, 1);
         if (n == 243) begin check("hold_busy_c243", busy, 0); note_valid = 0; end
         if (n == 244) check("hold_busy_c244", busy, 1);
         if (n == 356) check("hold_new_c356", output_note, 0);
         if (n == 357) check("hold_new_c357", output_note, 1);
      end
      // stop while the tone is high
      start_note(5, 0, 1);
      dn = 0;
      for (int n = 1; n <= 400; n++) begin
         @(negedge clk);
         if (done) dn++;
         if (n == 150) begin check("stop_out_before", output_note, 1); stop = 1; end
         if (n == 151) begin check("stop_out", output_note, 0); check("stop_busy", busy, 0); stop = 0; end
         if (n == 152) check("stop_ready", note_ready, 1);
      end
      check("stop_no_done", dn, 0);
      // reset mid-note
      start_note(5, 0, 1);
      dn = 0;
      for (int n = 1; n <= 400; n++) begin
         @(negedge clk);
         if (done) dn++;
         if (n == 150) rst_n = 0;
         if (n == 151) begin
            check("rstm_out", output_note, 0); check("rstm_busy", busy, 0);
            check("rstm_ready", note_ready, 0); check("rstm_done", done, 0);
            rst_n = 1;
         end
         if (n == 152) check("rstm_ready_back", note_ready, 1);
      end
      check("rstm_no_done", dn, 0);
      // randomized traffic, checked cycle by cycle against the model
      for (int i = 0; i < 20000; i++) begin
         @(negedge clk);
         note_valid = $urandom_range(7) == 0;
         note_code  = 4'($urandom);
         octave     = 2'($urandom);
         dur_ms     = 16'($urandom_range(2));
         stop       = $urandom_range(399) == 0;
         rst_n      = $urandom_range(2999) != 0;
      end
      @(negedge clk);
      note_valid = 0; stop = 0; rst_n = 1;
      repeat (5) @(negedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
   initial begin
      #2000000;
      $display("FAIL watchdog expired at %0t", $time);
      $fatal(1);
   end
endmodule
